// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory read port, decode valid/ready
// handshake and the branch redirect request.
interface imem_fetch_ctrl_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;

  // Fetch controller side.
  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  // Memory / decode / branch-unit side.
  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, waits RD_LAT cycles per access,
// buffers words in a 2-entry queue, handles redirects. Optional: FETCH_PERF_CNT_EN.
module imem_fetch_ctrl #(
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [63:0] PC_STEP   = 64'd4
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic [63:0]       startpc,
  imem_fetch_ctrl_if.master bus,
  output logic              fetch_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);
  localparam logic [1:0] Q_FULL   = 2'(BUF_DEPTH);

  state_t      state, state_nx;
  logic [63:0] pc;
  logic [63:0] addr_q;
  logic [3:0]  cnt;

  logic [1:0]  q_count, q_count_nx;
  logic [31:0] hd_data, tl_data;
  logic [63:0] hd_pc, tl_pc;

  logic        redir, redir_ok, push, pop;
  logic [1:0]  wr_slot;

  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = (q_count != 2'd0) && (state != S_HALT);
  assign bus.inst_data  = hd_data;
  assign bus.inst_pc    = hd_pc;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    redir    = bus.redirect_valid && (state != S_BOOT) && (state != S_HALT);
    redir_ok = (bus.redirect_pc[1:0] == 2'b00);
    pop      = bus.inst_valid && bus.inst_ready;
    push     = (state == S_WAIT) && (cnt == 4'd0) && !redir;
    wr_slot  = q_count - {1'b0, pop};

    q_count_nx = q_count;
    if (redir)              q_count_nx = 2'd0;
    else if (push && !pop)  q_count_nx = q_count + 2'd1;
    else if (pop && !push)  q_count_nx = q_count - 2'd1;

    state_nx = state;
    case (state)
      S_BOOT:  state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (push) state_nx = (q_count_nx < Q_FULL) ? S_ISSUE : S_HOLD;
      S_HOLD:  if (pop) state_nx = S_ISSUE;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_BOOT;
    endcase
    // Redirect outranks every other transition.
    if (redir) state_nx = redir_ok ? S_ISSUE : S_HALT;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) state <= S_BOOT;
    else         state <= state_nx;
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      pc        <= '0;
      addr_q    <= '0;
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else if (redir) begin
      if (redir_ok) pc <= bus.redirect_pc;
      else          fetch_err <= 1'b1;
    end else begin
      case (state)
        S_BOOT: pc <= startpc;
        S_ISSUE: begin
          addr_q <= pc;
          cnt    <= CNT_INIT;
        end
        S_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             pc  <= pc + PC_STEP;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the queue entries are reset too, because the head feeds inst_data and
  // inst_pc directly and those must read zero out of reset.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      q_count <= '0;
      hd_data <= '0;
      hd_pc   <= '0;
      tl_data <= '0;
      tl_pc   <= '0;
    end else begin
      q_count <= q_count_nx;
      if (!redir) begin
        if (pop) begin
          hd_data <= tl_data;
          hd_pc   <= tl_pc;
        end
        // Push lands in the slot left free after this edge's pop; it overrides the shift.
        if (push) begin
          if (wr_slot == 2'd0) begin
            hd_data <= bus.imem_data;
            hd_pc   <= addr_q;
          end else begin
            tl_data <= bus.imem_data;
            tl_pc   <= addr_q;
          end
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else if (redir) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (push && (fetch_cnt != '1))               fetch_cnt <= fetch_cnt + 32'd1;
      if ((state == S_HOLD) && (stall_cnt != '1))  stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl (RD_LAT=2, PC_STEP=4) with a small ROM model;
// also covers the FETCH_PERF_CNT_EN build when that macro is defined.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        resetl;
  logic [63:0] startpc;
  logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int n_cyc;

  imem_fetch_ctrl_if bus ();

  imem_fetch_ctrl dut (
    .CLK       (clk),
    .resetl    (resetl),
    .startpc   (startpc),
    .bus       (bus.master),
    .fetch_err (fetch_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h00:  mem_word = 32'hF840_03E9;
      64'h04:  mem_word = 32'hF840_83EA;
      64'h1C:  mem_word = 32'hB400_00AC;
      64'h28:  mem_word = 32'h17FF_FFFD;
      default: mem_word = 32'h1300_0000 | {16'h0000, a[15:0]};
    endcase
  endfunction

  always_comb bus.imem_data = mem_word(bus.imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Tick until inst_valid rises or the budget runs out; n returns ticks taken.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.inst_valid && n < max);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetl             = 1'b0;
    startpc            = 64'h0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    tick();
    tick();

    // Reset values
    check("rst_addr",  bus.imem_addr,  64'h0);
    check("rst_valid", bus.inst_valid, 64'h0);
    check("rst_data",  bus.inst_data,  64'h0);
    check("rst_pc",    bus.inst_pc,    64'h0);
    check("rst_err",   fetch_err,      64'h0);

    // 1: sequential fetch with decode always ready: BOOT + 3 cycles, then every 3
    bus.inst_ready = 1'b1;
    resetl = 1'b1;
    wait_valid(20, n_cyc);
    check("t1_first_lat", n_cyc,         64'd4);
    check("t1_data0",     bus.inst_data, 64'hF840_03E9);
    check("t1_pc0",       bus.inst_pc,   64'h0);
    wait_valid(20, n_cyc);
    check("t1_period",    n_cyc,         64'd3);
    check("t1_data1",     bus.inst_data, 64'hF840_83EA);
    check("t1_pc1",       bus.inst_pc,   64'h4);

    // 2: decode stalled, queue fills, FSM holds with address at 0x4
    resetl = 1'b0;
    bus.inst_ready = 1'b0;
    tick();
    tick();
    resetl = 1'b1;
    repeat (9) tick();
    check("t2_hold_addr", bus.imem_addr,  64'h4);
    check("t2_valid",     bus.inst_valid, 64'h1);
    check("t2_head_pc",   bus.inst_pc,    64'h0);
    check("t2_head_data", bus.inst_data,  64'hF840_03E9);
`ifdef FETCH_PERF_CNT_EN
    check("t2_fetch_cnt", fetch_cnt, 64'd2);
    check("t2_stall_cnt", stall_cnt, 64'd2);
`endif
    bus.inst_ready = 1'b1;
    tick();
    check("t2_second_pc",   bus.inst_pc,   64'h4);
    check("t2_second_data", bus.inst_data, 64'hF840_83EA);
    tick();
    check("t2_resume_addr", bus.imem_addr,  64'h8);
    check("t2_drained",     bus.inst_valid, 64'h0);

    // 3: jump to 0x28, then redirect to 0x1C while that access is in flight
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h28;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check("t3_addr28", bus.imem_addr, 64'h28);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h1C;
    tick();
    bus.redirect_valid = 1'b0;
    check("t3_flushed", bus.inst_valid, 64'h0);
`ifdef FETCH_PERF_CNT_EN
    check("t3_fetch_cnt_clr", fetch_cnt, 64'd0);
    check("t3_stall_cnt_clr", stall_cnt, 64'd0);
`endif
    wait_valid(20, n_cyc);
    check("t3_lat",  n_cyc,         64'd3);
    check("t3_pc",   bus.inst_pc,   64'h1C);
    check("t3_data", bus.inst_data, 64'hB400_00AC);

    // 4: redirect on the same edge as the head is popped
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h40;
    tick();
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
    check("t4_empty", bus.inst_valid, 64'h0);
    wait_valid(20, n_cyc);
    check("t4_lat",  n_cyc,         64'd3);
    check("t4_pc",   bus.inst_pc,   64'h40);
    check("t4_data", bus.inst_data, 64'h1300_0040);

    // 5: misaligned target halts with sticky error; only reset recovers
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h22;
    tick();
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b1;
    check("t5_err",   fetch_err,      64'h1);
    check("t5_valid", bus.inst_valid, 64'h0);
    repeat (5) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h100;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check("t5_halt_valid", bus.inst_valid, 64'h0);
    check("t5_halt_addr",  bus.imem_addr,  64'h40);
    check("t5_halt_err",   fetch_err,      64'h1);
    resetl  = 1'b0;
    startpc = 64'h1C;
    #1;
    check("t5_rst_err", fetch_err, 64'h0);
    tick();
    resetl = 1'b1;
    wait_valid(20, n_cyc);
    check("t5_boot_lat", n_cyc,         64'd4);
    check("t5_boot_pc",  bus.inst_pc,   64'h1C);
    check("t5_boot_dat", bus.inst_data, 64'hB400_00AC);

    // 6: asynchronous reset in the middle of a WAIT
    tick();
    tick();
    check("t6_wait_addr", bus.imem_addr, 64'h20);
    #3;
    resetl = 1'b0;
    #1;
    check("t6_async_addr",  bus.imem_addr,  64'h0);
    check("t6_async_valid", bus.inst_valid, 64'h0);
    check("t6_async_pc",    bus.inst_pc,    64'h0);

    // PC wraps from the top of the address space to zero
    startpc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    resetl = 1'b1;
    wait_valid(20, n_cyc);
    check("wrap_pc_top",  bus.inst_pc,   64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_dat_top", bus.inst_data, 64'h1300_FFFC);
    wait_valid(20, n_cyc);
    check("wrap_lat",     n_cyc,         64'd3);
    check("wrap_pc_zero", bus.inst_pc,   64'h0);
    check("wrap_dat_zero", bus.inst_data, 64'hF840_03E9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
